// File: rtl/mips_hazard_ctl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline with a shadow tag pipeline.
// Build option: define FORWARDING_EN for EX-stage forwarding; otherwise a full interlock is used.
module mips_hazard_ctl #(
    parameter int REGW     = 5,
    parameter int BR_STAGE = 3,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [REGW-1:0] id_dst,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_jump,
    input  logic            br_taken,
    input  logic            ext_stall,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic            exmem_bubble,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic [REGW-1:0] dst;
    } slot_t;

    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    slot_t id_slot;

    logic [1:0][1:0]    fwd_q, fwd_d;
    logic [1:0][1:0]    fwd_sel;
    logic [CNTW-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0]    flush_cnt_q, flush_cnt_d;

    logic [1:0][REGW-1:0] src;
    logic [1:0]           src_used;
    logic [1:0]           src_hazard;
    logic                 hazard;
    logic                 advance;
    logic                 unused_bits;

    function automatic logic slot_writes(input slot_t s, input logic [REGW-1:0] r);
        return s.valid && s.regwrite && (s.dst == r) && (r != '0);
    endfunction

    assign src      = {id_rt, id_rs};
    assign src_used = {id_uses_rt, id_uses_rs};
    assign id_slot  = '{valid: id_valid, regwrite: id_regwrite, memread: id_memread, dst: id_dst};
    assign advance  = !ext_stall;

    // Index 0 is the rs operand (fwd_a), index 1 the rt operand (fwd_b).
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
`ifdef FORWARDING_EN
        assign src_hazard[gi] = src_used[gi] && ex_q.valid && ex_q.memread &&
                                (ex_q.dst == src[gi]) && (src[gi] != '0);
        assign fwd_sel[gi]    = slot_writes(ex_q,  src[gi]) ? 2'b10 :
                                slot_writes(mem_q, src[gi]) ? 2'b01 : 2'b00;
`else
        // Register file is write-then-read across cycles, so WB still blocks.
        assign src_hazard[gi] = src_used[gi] && (slot_writes(ex_q,  src[gi]) ||
                                                 slot_writes(mem_q, src[gi]) ||
                                                 slot_writes(wb_q,  src[gi]));
        assign fwd_sel[gi]    = 2'b00;
`endif
    end

    assign hazard = id_valid && (|src_hazard);

    // Pipeline-register controls, strict priority order.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (ext_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (br_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = (BR_STAGE == 3);
        end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_valid && id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        fwd_d       = fwd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (advance) begin
            ex_d  = idex_bubble  ? '0 : id_slot;
            mem_d = exmem_bubble ? '0 : ex_q;
            wb_d  = mem_q;
            for (int i = 0; i < 2; i++) begin
                fwd_d[i] = idex_bubble ? 2'b00 : fwd_sel[i];
            end
            if (br_taken) begin
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNTW'(1);
            end else if (hazard) begin
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_q       <= fwd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_q[0];
    assign fwd_b     = fwd_q[1];
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Tag bits that only some build options consume.
    assign unused_bits = ^{wb_q, mem_q.memread, id_memread};

endmodule

// File: tb/tb_mips_hazard_ctl.sv
// Self-checking bench for mips_hazard_ctl: directed scenarios plus random traffic against a slot-list model.
module tb_mips_hazard_ctl;
    localparam int REGW     = 5;
    localparam int BR_STAGE = 3;
    localparam int CNTW     = 5;
    localparam int CMAX     = (1 << CNTW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, id_valid, id_uses_rs, id_uses_rt;
    logic [REGW-1:0] id_rs, id_rt, id_dst;
    logic            id_regwrite, id_memread, id_jump, br_taken, ext_stall;
    logic            pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble;
    logic [1:0]      fwd_a, fwd_b;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    mips_hazard_ctl #(.REGW(REGW), .BR_STAGE(BR_STAGE), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_jump(id_jump),
        .br_taken(br_taken), .ext_stall(ext_stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_bubble(exmem_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
    typedef struct {bit v; bit rw; bit mr; int dst;} slot_t;
    slot_t pipe [3];
    int m_fwd [2];
    int m_sc, m_fc;
    int checks = 0;
    int errors = 0;
    int last_ifw;

    task automatic chk(string tag, logic [31:0] obs, int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit writes(slot_t s, int r);
        return s.v && s.rw && s.dst == r && r != 0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) pipe[s] = '{default: 0};
        m_fwd[0] = 0; m_fwd[1] = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic set_id(bit v, int rs, int rt, bit urs, bit urt, int dst, bit rw, bit mr, bit jmp);
        id_valid = v; id_rs = REGW'(rs); id_rt = REGW'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_dst = REGW'(dst); id_regwrite = rw; id_memread = mr; id_jump = jmp;
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic step(string tag);
        int srcs [2];
        bit used [2];
        bit hz;
        int e_pcw, e_ifw, e_iff, e_idb, e_exb;
        slot_t idslot, empty;
        #2;
        srcs[0] = int'(id_rs); srcs[1] = int'(id_rt);
        used[0] = id_uses_rs;  used[1] = id_uses_rt;
        hz = 0;
        for (int k = 0; k < 2; k++) begin
            if (id_valid && used[k] && srcs[k] != 0) begin
`ifdef FORWARDING_EN
                if (pipe[0].v && pipe[0].mr && pipe[0].dst == srcs[k]) hz = 1;
`else
                for (int s = 0; s < 3; s++) if (writes(pipe[s], srcs[k])) hz = 1;
`endif
            end
        end
        if (reset)              begin e_pcw = 0; e_ifw = 0; e_iff = 1; e_idb = 1; e_exb = 1; end
        else if (ext_stall)     begin e_pcw = 0; e_ifw = 0; e_iff = 0; e_idb = 0; e_exb = 0; end
        else if (br_taken)      begin e_pcw = 1; e_ifw = 1; e_iff = 1; e_idb = 1; e_exb = (BR_STAGE == 3) ? 1 : 0; end
        else if (hz)            begin e_pcw = 0; e_ifw = 0; e_iff = 0; e_idb = 1; e_exb = 0; end
        else if (id_valid && id_jump) begin e_pcw = 1; e_ifw = 1; e_iff = 1; e_idb = 0; e_exb = 0; end
        else                    begin e_pcw = 1; e_ifw = 1; e_iff = 0; e_idb = 0; e_exb = 0; end
        chk({tag, ".pc_write"}, pc_write, e_pcw);
        chk({tag, ".ifid_write"}, ifid_write, e_ifw);
        chk({tag, ".ifid_flush"}, ifid_flush, e_iff);
        chk({tag, ".idex_bubble"}, idex_bubble, e_idb);
        chk({tag, ".exmem_bubble"}, exmem_bubble, e_exb);
        chk({tag, ".fwd_a"}, fwd_a, m_fwd[0]);
        chk({tag, ".fwd_b"}, fwd_b, m_fwd[1]);
        chk({tag, ".stall_cnt"}, stall_cnt, m_sc);
        chk({tag, ".flush_cnt"}, flush_cnt, m_fc);
        last_ifw = e_ifw;
        idslot = '{v: id_valid, rw: id_regwrite, mr: id_memread, dst: int'(id_dst)};
        empty  = '{default: 0};
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!ext_stall) begin
            for (int k = 0; k < 2; k++) begin
`ifdef FORWARDING_EN
                m_fwd[k] = e_idb ? 0 : writes(pipe[0], srcs[k]) ? 2 : writes(pipe[1], srcs[k]) ? 1 : 0;
`else
                m_fwd[k] = 0;
`endif
            end
            if (br_taken) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            else if (hz)  m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            pipe[2] = pipe[1];
            pipe[1] = e_exb ? empty : pipe[0];
            pipe[0] = e_idb ? empty : idslot;
        end
        #1;
    endtask

    // Hold the current ID instruction until it is accepted; reports stall cycles spent.
    task automatic issue(string tag, output int stalls);
        bit done;
        done = 0;
        stalls = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            step(tag);
            if (last_ifw == 1) done = 1;
            else stalls++;
        end
        chk({tag, ".issued"}, done, 1);
    endtask

    int n, sc0, fc0;

    initial begin
        reset = 1'b1; br_taken = 1'b0; ext_stall = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step("reset");
        reset = 1'b0;

        // Back-to-back ALU dependency: add r3<-r1+r2 ; sub r4<-r3-r1
        set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); issue("b2b.add", n);
        set_id(1, 3, 1, 1, 1, 4, 1, 0, 0); issue("b2b.sub", n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
        chk("b2b.fwd_a_ex", fwd_a, 2);
        chk("b2b.stalls", n, 0);
`else
        chk("b2b.fwd_a_ex", fwd_a, 0);
        chk("b2b.stalls", n, 3);
        chk("b2b.stall_cnt", stall_cnt, 3);
`endif

        // Distance-2 dependency, then a producer writing r0.
        set_id(1, 1, 2, 1, 1, 3, 1, 0, 0);  issue("d2.add", n);
        set_id(1, 8, 9, 1, 1, 10, 1, 0, 0); issue("d2.indep", n);
        set_id(1, 3, 8, 1, 1, 11, 1, 0, 0); issue("d2.use", n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
        chk("d2.fwd_a_ex", fwd_a, 1);
`else
        chk("d2.fwd_a_ex", fwd_a, 0);
`endif
        set_id(1, 1, 2, 1, 1, 0, 1, 0, 0); issue("r0.prod", n);
        set_id(1, 0, 0, 1, 1, 12, 1, 0, 0); issue("r0.use", n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0.stalls", n, 0);
        chk("r0.fwd_a_ex", fwd_a, 0);

        // Load-use: lw r5 ; add r6<-r5+r5
        sc0 = int'(stall_cnt);
        set_id(1, 1, 0, 1, 0, 5, 1, 1, 0); issue("lu.lw", n);
        set_id(1, 5, 5, 1, 1, 6, 1, 0, 0); issue("lu.add", n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
        chk("lu.stalls", n, 1);
        chk("lu.fwd_a_ex", fwd_a, 1);
        chk("lu.fwd_b_ex", fwd_b, 1);
        chk("lu.stall_delta", int'(stall_cnt) - sc0, 1);
`else
        chk("lu.stalls", n, 3);
        chk("lu.stall_delta", int'(stall_cnt) - sc0, 3);
`endif

        // Taken branch on the same cycle as a load-use condition.
        sc0 = int'(stall_cnt); fc0 = int'(flush_cnt);
        set_id(1, 1, 0, 1, 0, 5, 1, 1, 0); issue("brlu.lw", n);
        set_id(1, 5, 5, 1, 1, 6, 1, 0, 0);
        br_taken = 1'b1;
        #2;
        chk("brlu.exmem_bubble", exmem_bubble, 1);
        chk("brlu.pc_write", pc_write, 1);
        step("brlu.br");
        br_taken = 1'b0;
        chk("brlu.stall_delta", int'(stall_cnt) - sc0, 0);
        chk("brlu.flush_delta", int'(flush_cnt) - fc0, 1);

        // Pending branch under a 4-cycle freeze, then released.
        fc0 = int'(flush_cnt);
        set_id(1, 1, 2, 1, 1, 7, 1, 0, 0);
        br_taken = 1'b1; ext_stall = 1'b1;
        repeat (4) step("frz.hold");
        chk("frz.flush_held", int'(flush_cnt) - fc0, 0);
        ext_stall = 1'b0;
        #2;
        chk("frz.release_flush", ifid_flush, 1);
        step("frz.release");
        br_taken = 1'b0;
        chk("frz.flush_delta", int'(flush_cnt) - fc0, 1);

        // Reset in the middle of a frozen branch.
        br_taken = 1'b1; ext_stall = 1'b1;
        step("rst.pre");
        reset = 1'b1;
        step("rst.mid");
        chk("rst.stall_cnt", stall_cnt, 0);
        chk("rst.flush_cnt", flush_cnt, 0);
        chk("rst.fwd_a", fwd_a, 0);
        reset = 1'b0; br_taken = 1'b0; ext_stall = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst.post");

        // Random traffic over a small register set to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            if (last_ifw == 1)
                set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 9) == 0);
            if (!(ext_stall && br_taken)) br_taken = ($urandom_range(0, 11) == 0);
            ext_stall = ($urandom_range(0, 7) == 0);
            step("rnd");
        end
        br_taken = 1'b0; ext_stall = 1'b0;

        // Drive both counters into saturation.
        for (int i = 0; i < CMAX + 4; i++) begin
            set_id(1, 1, 0, 1, 0, 5, 1, 1, 0); issue("sat.lw", n);
            set_id(1, 5, 5, 1, 1, 6, 1, 0, 0); issue("sat.add", n);
            br_taken = 1'b1;
            step("sat.br");
            br_taken = 1'b0;
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("sat.end");
        chk("sat.stall_cnt", stall_cnt, CMAX);
        chk("sat.flush_cnt", flush_cnt, CMAX);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_hazard_ctl.md
# mips_hazard_ctl

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It keeps its own shadow pipeline of destination/control tags for the EX, MEM and WB slots. From those tags it generates:
- registered forwarding selects for the EX-stage operand muxes;
- load-use interlock (PC/IF-ID hold plus ID/EX bubble);
- branch/jump flushes, with a parametrised branch-resolve stage;
- a global freeze for external wait states.

It replaces the ad-hoc jump flush and unguarded forwarding in the core's top level, and also provides saturating stall/flush performance counters.

## Interface
Parameters:
- REGW, 5, register-address width
- BR_STAGE, 3, stage where branches resolve: 2 = EX, 3 = MEM
- CNTW, 16, performance-counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_rs, id_rt  in  REGW  ID source register numbers
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_dst  in  REGW  ID destination register, after the RegDst selection
- id_regwrite, id_memread, id_jump  in  1  ID control bits
- br_taken  in  1  taken branch at stage BR_STAGE
- ext_stall  in  1  freeze all stages (memory wait)
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  load zero (nop) into IF/ID
- idex_bubble  out  1  load zero control bits into ID/EX
- exmem_bubble  out  1  load zero control bits into EX/MEM
- fwd_a, fwd_b  out  2  EX operand select: 00 = ID/EX, 01 = MEM/WB, 10 = EX/MEM
- stall_cnt, flush_cnt  out  CNTW  performance counters

## Operation
Shadow slots:
- EX, MEM and WB each hold {valid, regwrite, memread, dst}.
- "Advance" = ext_stall is 0. On advance: ID→EX (or a bubble), EX→MEM (or a bubble when exmem_bubble is 1), MEM→WB.
- When ext_stall is 1, all slots, fwd_a/fwd_b and both counters hold.

A slot "writes r" when valid & regwrite & dst == r & r != 0. Register 0 is never forwarded and never causes a stall.

Forwarding (FORWARDING_EN defined):
- On advance, fwd_a is loaded from id_rs as follows, first match wins:
  - 10 if the EX slot writes id_rs;
  - 01 if the MEM slot writes id_rs;
  - 00 otherwise.
- fwd_b is computed the same way from id_rt.
- If a bubble is inserted into EX instead of the ID instruction, fwd_a and fwd_b load 00.

Load-use stall:
- Condition: id_valid, the EX slot is valid with memread set, and its dst matches a used source (rs with id_uses_rs, or rt with id_uses_rt), dst != 0.
- Action: pc_write=0, ifid_write=0, idex_bubble=1.
- Lasts exactly 1 cycle. Afterwards the load is in MEM and the value is forwarded via 01 on the next advance.

Branch flush (br_taken=1, no ext_stall):
- ifid_flush=1 and idex_bubble=1.
- If BR_STAGE is 3, exmem_bubble=1 as well.
- pc_write=1 and ifid_write=1.

Jump:
- id_valid & id_jump with no branch flush and no stall gives ifid_flush=1 only.

Priority:
1. reset
2. ext_stall: all enables 0, all flush/bubble outputs 0
3. br_taken
4. load-use / interlock stall
5. jump
6. normal: pc_write=1, ifid_write=1, all others 0

A taken branch overrides a load-use stall or jump on the same cycle, because the stalled instruction is wrong-path.

Counters:
- stall_cnt increments on each advancing cycle with a stall active.
- flush_cnt increments on each br_taken flush.
- Both saturate at 2^CNTW−1 and do not wrap.

## Timing
- pc_write, ifid_write, ifid_flush, idex_bubble and exmem_bubble are combinational from the inputs and shadow state, with no latency.
- fwd_a/fwd_b are registered and valid in the cycle the instruction occupies EX.
- Branch penalty: 2 flushed instructions if BR_STAGE is 2, 3 if BR_STAGE is 3. Jump penalty: 1.
- While reset is high:
  - slots are invalid; fwd_a=fwd_b=00; counters 0;
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1.
- On the first cycle after reset: normal advance.
- Reset asserted mid-stall or mid-flush overrides everything on that edge.
- br_taken must be held by its source while ext_stall is 1. It is acted on at the first cycle with ext_stall=0.

## Configuration
- FORWARDING_EN defined: forwarding and the single-cycle load-use stall, as above.
- FORWARDING_EN not defined:
  - fwd_a and fwd_b are tied to 00.
  - Full interlock: stall (same action as load-use) while any of EX, MEM or WB writes a used ID source.
  - The register file is write-then-read in different cycles, hence WB is included in the check.
  - The stall repeats each cycle until the producer leaves WB, giving up to 3 stall cycles.

## Test plan
- Back-to-back ALU dependency: add r3←r1+r2, then sub r4←r3−r1 → fwd_a=10 in sub's EX cycle, with no stall.
- Distance-2 dependency with one independent instruction between → fwd_a=01. A producer with dst=0 → fwd=00.
- Load-use: lw r5 followed immediately by add r6←r5+r5 →
  - exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1;
  - then fwd_a=fwd_b=01;
  - stall_cnt=1.
- br_taken with BR_STAGE=3, coinciding with a load-use condition →
  - ifid_flush=1, idex_bubble=1, exmem_bubble=1, pc_write=1;
  - stall_cnt unchanged, flush_cnt=1.
- ext_stall held 4 cycles during a pending br_taken → all outputs hold, then the flush fires on the release cycle. Reset asserted mid-sequence → reset values on the next edge.
- FORWARDING_EN undefined, back-to-back dependency → 3 stall cycles, fwd always 00, stall_cnt=3. Drive the counters to 2^CNTW−1 → they saturate.
